// File: rtl/cache_mem_pkg.sv
// Shared types and sizing helpers for the cache line memory controller.
// Line and word-address widths are derived here so the cache and controller stay in step.
package cache_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_DRAIN,
    DONE
  } mem_state_e;

  localparam int unsigned WordW = 32;

  function automatic int unsigned line_size(input int unsigned line_addr_len);
    return 32'd1 << line_addr_len;
  endfunction

  function automatic int unsigned word_addr_w(input int unsigned addr_len,
                                              input int unsigned line_addr_len);
    return addr_len + line_addr_len;
  endfunction

endpackage

// File: rtl/mem_valid_delay.sv
// Delays the SRAM read-issue strobe by LAT cycles.
// The output marks the cycles in which sram_rdata carries a requested word.
module mem_valid_delay #(
  parameter int unsigned LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic valid
);

  logic [LAT-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= LAT'({sr_q, issue});
    end
  end

  assign valid = sr_q[LAT-1];

endmodule

// File: rtl/cache_line_mem_ctrl.sv
// Line-granular controller between the data cache and a word-wide synchronous SRAM.
// Each line is moved as LINE_SIZE single-word accesses; gnt pulses once per finished line.
module cache_line_mem_ctrl
  import cache_mem_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 7,
  parameter int unsigned SRAM_LAT      = 2
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [ADDR_LEN-1:0]                                addr,
  input  logic                                               rd_req,
  input  logic                                               wr_req,
  input  logic [WordW*line_size(LINE_ADDR_LEN)-1:0]          wr_line,
  output logic [WordW*line_size(LINE_ADDR_LEN)-1:0]          rd_line,
  output logic                                               gnt,
  output logic                                               sram_en,
  output logic                                               sram_we,
  output logic [word_addr_w(ADDR_LEN, LINE_ADDR_LEN)-1:0]    sram_addr,
  output logic [WordW-1:0]                                   sram_wdata,
  input  logic [WordW-1:0]                                   sram_rdata
);

  localparam int unsigned LineSize = line_size(LINE_ADDR_LEN);
  localparam int unsigned LineW    = WordW * LineSize;
  localparam logic [LINE_ADDR_LEN-1:0] LastIdx = LINE_ADDR_LEN'(LineSize - 1);

  mem_state_e               state_q, state_d;
  logic [ADDR_LEN-1:0]      addr_q, addr_d;
  logic [LineW-1:0]         wline_q, wline_d;
  logic [LineW-1:0]         rd_line_q, rd_line_d;
  logic [LINE_ADDR_LEN-1:0] idx_q, idx_d;
  logic [LINE_ADDR_LEN-1:0] ret_idx_q, ret_idx_d;
  logic                     issue;
  logic                     rd_valid;

  mem_valid_delay #(
    .LAT(SRAM_LAT)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .issue(issue),
    .valid(rd_valid)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wline_d    = wline_q;
    idx_d      = idx_q;
    ret_idx_d  = ret_idx_q;
    rd_line_d  = rd_line_q;
    gnt        = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    issue      = 1'b0;

    unique case (state_q)
      IDLE: begin
        idx_d     = '0;
        ret_idx_d = '0;
        // A write takes precedence if both requests are raised together.
        if (wr_req) begin
          addr_d  = addr;
          wline_d = wr_line;
          state_d = WRITE;
        end else if (rd_req) begin
          addr_d  = addr;
          state_d = READ;
        end
      end
      WRITE: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = {addr_q, idx_q};
        sram_wdata = wline_q[idx_q*WordW +: WordW];
        if (idx_q == LastIdx) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READ: begin
        sram_en   = 1'b1;
        sram_addr = {addr_q, idx_q};
        issue     = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = READ_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READ_DRAIN: begin
        if (rd_valid && (ret_idx_q == LastIdx)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        gnt     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Returned words can arrive while later reads are still being issued.
    if (rd_valid && ((state_q == READ) || (state_q == READ_DRAIN))) begin
      rd_line_d[ret_idx_q*WordW +: WordW] = sram_rdata;
      if (ret_idx_q != LastIdx) begin
        ret_idx_d = ret_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wline_q   <= '0;
      rd_line_q <= '0;
      idx_q     <= '0;
      ret_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wline_q   <= wline_d;
      rd_line_q <= rd_line_d;
      idx_q     <= idx_d;
      ret_idx_q <= ret_idx_d;
    end
  end

  assign rd_line = rd_line_q;

endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Bench for cache_line_mem_ctrl: three instances (SRAM latency 2, 1, 4) against
// word-wide SRAM models and a line-level reference of memory contents.
module tb_cache_line_mem_ctrl;

  localparam int LS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [6:0]  addr       [3];
  logic        rd_req     [3];
  logic        wr_req     [3];
  logic [255:0] wr_line   [3];
  logic [255:0] rd_line   [3];
  logic        gnt        [3];
  logic        sram_en    [3];
  logic        sram_we    [3];
  logic [9:0]  sram_addr  [3];
  logic [31:0] sram_wdata [3];
  logic [31:0] sram_rdata [3];

  logic [31:0] sram_mem [3][1024];
  logic [31:0] pipe     [3][4];

  logic [255:0] ref_line [3][128];
  logic [255:0] exp_rd   [3];
  logic [6:0]   written_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  cache_line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(7), .SRAM_LAT(2)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr[0]), .rd_req(rd_req[0]), .wr_req(wr_req[0]),
    .wr_line(wr_line[0]), .rd_line(rd_line[0]), .gnt(gnt[0]), .sram_en(sram_en[0]),
    .sram_we(sram_we[0]), .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]),
    .sram_rdata(sram_rdata[0])
  );

  cache_line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(7), .SRAM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr[1]), .rd_req(rd_req[1]), .wr_req(wr_req[1]),
    .wr_line(wr_line[1]), .rd_line(rd_line[1]), .gnt(gnt[1]), .sram_en(sram_en[1]),
    .sram_we(sram_we[1]), .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]),
    .sram_rdata(sram_rdata[1])
  );

  cache_line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(7), .SRAM_LAT(4)) u_dut2 (
    .clk(clk), .rst(rst), .addr(addr[2]), .rd_req(rd_req[2]), .wr_req(wr_req[2]),
    .wr_line(wr_line[2]), .rd_line(rd_line[2]), .gnt(gnt[2]), .sram_en(sram_en[2]),
    .sram_we(sram_we[2]), .sram_addr(sram_addr[2]), .sram_wdata(sram_wdata[2]),
    .sram_rdata(sram_rdata[2])
  );

  // SRAM models: data appears LAT cycles after the read is issued.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (sram_en[u] && sram_we[u]) sram_mem[u][sram_addr[u]] <= sram_wdata[u];
      pipe[u][0] <= sram_mem[u][sram_addr[u]];
      for (int k = 1; k < 4; k++) pipe[u][k] <= pipe[u][k-1];
    end
  end

  assign sram_rdata[0] = pipe[0][1];
  assign sram_rdata[1] = pipe[1][0];
  assign sram_rdata[2] = pipe[2][3];

  function automatic int lat_of(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [255:0] seq_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < LS; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < LS; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise a request in an idle cycle, wait (bounded) for gnt, return cycles to gnt.
  task automatic do_req(input int u, input bit wr, input bit rd, input logic [6:0] a,
                        input logic [255:0] line, output int lat);
    @(posedge clk); #1;
    check("gnt_low_before_req", 256'(gnt[u]), 256'(0));
    check("rd_line_stable", rd_line[u], exp_rd[u]);
    addr[u]    = a;
    wr_line[u] = line;
    wr_req[u]  = wr;
    rd_req[u]  = rd;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (gnt[u]) break;
    end
    wr_req[u] = 1'b0;
    rd_req[u] = 1'b0;
  endtask

  task automatic do_write(input int u, input logic [6:0] a, input logic [255:0] line,
                          input bit also_rd);
    int lat;
    logic [255:0] got;
    do_req(u, 1'b1, also_rd, a, line, lat);
    check("wr_latency", 256'(lat), 256'(LS + 1));
    ref_line[u][a] = line;
    for (int i = 0; i < LS; i++) got[i*32 +: 32] = sram_mem[u][{a, 3'(i)}];
    check("wr_sram_words", got, ref_line[u][a]);
    check("wr_keeps_rd_line", rd_line[u], exp_rd[u]);
    if (u == 0) written_q.push_back(a);
  endtask

  task automatic do_read(input int u, input logic [6:0] a);
    int lat;
    do_req(u, 1'b0, 1'b1, a, '0, lat);
    check("rd_latency", 256'(lat), 256'(LS + lat_of(u) + 1));
    check("rd_line_data", rd_line[u], ref_line[u][a]);
    exp_rd[u] = ref_line[u][a];
  endtask

  int          pulses;
  logic [6:0]  ra;
  logic [255:0] rl;

  initial begin
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      addr[u] = '0; rd_req[u] = 1'b0; wr_req[u] = 1'b0; wr_line[u] = '0; exp_rd[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 256'(gnt[0]), 256'(0));
    check("rst_sram_en_we", 256'({sram_en[0], sram_we[0]}), 256'(0));
    check("rst_sram_addr", 256'(sram_addr[0]), 256'(0));
    check("rst_sram_wdata", 256'(sram_wdata[0]), 256'(0));
    check("rst_rd_line", rd_line[0], 256'(0));
    rst = 1'b1;

    // Directed write then read of line 0x15.
    do_write(0, 7'h15, seq_line(32'hA0), 1'b0);
    do_read(0, 7'h15);

    // Random mix of line writes and reads of previously written lines.
    for (int n = 0; n < 10; n++) begin
      if ((written_q.size() < 2) || ($urandom_range(0, 1) == 0)) begin
        do_write(0, 7'($urandom_range(0, 127)), rand_line(), 1'b0);
      end else begin
        do_read(0, written_q[$urandom_range(0, written_q.size() - 1)]);
      end
    end

    // Swap-out then swap-in with no idle gap between them.
    do_write(0, 7'h42, rand_line(), 1'b0);
    do_write(0, 7'h02, rand_line(), 1'b0);
    do_read(0, 7'h42);

    // Both requests high: the write is performed, rd_line untouched.
    do_write(0, 7'h33, rand_line(), 1'b1);

    // Reset in the middle of a line read.
    @(posedge clk); #1;
    addr[0]   = 7'h15;
    rd_req[0] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rst_mid_read_idx3", 256'({sram_en[0], sram_addr[0]}), 256'({1'b1, 7'h15, 3'd3}));
    rst       = 1'b0;
    rd_req[0] = 1'b0;
    #1;
    check("rst_mid_gnt", 256'(gnt[0]), 256'(0));
    check("rst_mid_sram_en", 256'(sram_en[0]), 256'(0));
    check("rst_mid_rd_line", rd_line[0], 256'(0));
    for (int u = 0; u < 3; u++) exp_rd[u] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (gnt[0]) pulses++;
    end
    check("rst_no_gnt", 256'(pulses), 256'(0));
    do_write(0, 7'h16, seq_line(32'h500), 1'b0);
    do_read(0, 7'h15);

    // Latency sweep on the SRAM_LAT=1 and SRAM_LAT=4 instances.
    for (int u = 1; u < 3; u++) begin
      do_write(u, 7'h15, seq_line(32'hA0), 1'b0);
      do_read(u, 7'h15);
      for (int n = 0; n < 3; n++) begin
        ra = 7'($urandom_range(0, 127));
        rl = rand_line();
        do_write(u, ra, rl, 1'b0);
        do_read(u, ra);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
